// File: rtl/seg_scan_decoder.sv
// Readback decoder for a multiplexed active-low 7-segment bus: settles each digit, decodes to BCD and publishes whole frames.
// Optional per-digit decimal-point capture is enabled with `define SEG_SCAN_DP_CAPTURE_EN.
module seg_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic [7:0]              seg_in,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    frame_valid,
    output logic                    decode_err,
`ifdef SEG_SCAN_DP_CAPTURE_EN
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    output logic                    stale
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] STALE_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HELD
    } state_t;

    logic [NUM_DIGITS-1:0] an_r;
    logic [7:0]            seg_r;
    logic [NUM_DIGITS-1:0] an_d;
    logic [7:0]            seg_d;
    logic                  sel_valid;
    logic                  changed;

    state_t                state_reg;
    state_t                state_next;
    logic [SW-1:0]         settle_cnt_reg;
    logic [SW-1:0]         settle_cnt_next;
    logic                  capture;

    logic [3:0]            dec_bcd;
    logic                  dec_blank;
    logic                  dec_illegal;

    logic [NUM_DIGITS-1:0] cap_mask;
    logic                  frame_fire;
    logic                  shadow_err_reg;
    logic [TW-1:0]         stale_cnt_reg;

    // an_d/seg_d hold the previous sample so stability is judged on registered data only
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            an_r  <= '1;
            seg_r <= '1;
            an_d  <= '1;
            seg_d <= '1;
        end else begin
            an_r  <= an_in;
            seg_r <= seg_in;
            an_d  <= an_r;
            seg_d <= seg_r;
        end
    end

    assign sel_valid = $onehot(~an_r);
    assign changed   = (an_r != an_d) || (seg_r != seg_d);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_WAIT;
            settle_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        capture         = 1'b0;
        case (state_reg)
            ST_WAIT: begin
                settle_cnt_next = '0;
                if (sel_valid) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (changed) begin
                    settle_cnt_next = '0;
                    state_next      = sel_valid ? ST_SETTLE : ST_WAIT;
                end else if (settle_cnt_reg == SETTLE_LAST) begin
                    capture         = sel_valid;
                    settle_cnt_next = '0;
                    state_next      = ST_HELD;
                end else begin
                    settle_cnt_next = settle_cnt_reg + SW'(1);
                end
            end
            ST_HELD: begin
                if (changed) begin
                    settle_cnt_next = '0;
                    state_next      = sel_valid ? ST_SETTLE : ST_WAIT;
                end
            end
            default: begin
                settle_cnt_next = '0;
                state_next      = ST_WAIT;
            end
        endcase
    end

    // Decimal point (bit 0) plays no part in the digit value
    always_comb begin
        dec_bcd     = 4'h0;
        dec_blank   = 1'b0;
        dec_illegal = 1'b0;
        case (seg_r[7:1])
            7'b0000001: dec_bcd = 4'd0;
            7'b1001111: dec_bcd = 4'd1;
            7'b0010010: dec_bcd = 4'd2;
            7'b0000110: dec_bcd = 4'd3;
            7'b1001100: dec_bcd = 4'd4;
            7'b0100100: dec_bcd = 4'd5;
            7'b0100000: dec_bcd = 4'd6;
            7'b0001111: dec_bcd = 4'd7;
            7'b0000000: dec_bcd = 4'd8;
            7'b0000100: dec_bcd = 4'd9;
            7'b1111111: dec_blank = 1'b1;
            default: begin
                dec_bcd     = 4'hF;
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign frame_fire = &cap_mask;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
        logic       hit;
        logic       cap_reg;
        logic [3:0] shadow_bcd_reg;
        logic       shadow_blank_reg;
        logic [3:0] bcd_reg;
        logic       blank_reg;

        assign hit = capture & ~an_r[gi];

        // A capture coinciding with frame publication belongs to the next frame
        always_ff @(posedge clk_100MHz or posedge reset) begin
            if (reset) begin
                cap_reg          <= 1'b0;
                shadow_bcd_reg   <= 4'h0;
                shadow_blank_reg <= 1'b0;
                bcd_reg          <= 4'h0;
                blank_reg        <= 1'b1;
            end else begin
                if (frame_fire) begin
                    bcd_reg   <= shadow_bcd_reg;
                    blank_reg <= shadow_blank_reg;
                end
                if (hit) begin
                    cap_reg          <= 1'b1;
                    shadow_bcd_reg   <= dec_bcd;
                    shadow_blank_reg <= dec_blank;
                end else if (frame_fire) begin
                    cap_reg <= 1'b0;
                end
            end
        end

        assign cap_mask[gi]         = cap_reg;
        assign bcd_out[4*gi +: 4]   = bcd_reg;
        assign blank_mask[gi]       = blank_reg;

`ifdef SEG_SCAN_DP_CAPTURE_EN
        logic shadow_dp_reg;
        logic dp_reg;

        always_ff @(posedge clk_100MHz or posedge reset) begin
            if (reset) begin
                shadow_dp_reg <= 1'b0;
                dp_reg        <= 1'b0;
            end else begin
                if (frame_fire) begin
                    dp_reg <= shadow_dp_reg;
                end
                if (hit) begin
                    shadow_dp_reg <= ~seg_r[0];
                end
            end
        end

        assign dp_out[gi] = dp_reg;
`endif
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            shadow_err_reg <= 1'b0;
            frame_valid    <= 1'b0;
            decode_err     <= 1'b0;
            stale_cnt_reg  <= '0;
        end else begin
            frame_valid <= frame_fire;
            if (frame_fire) begin
                decode_err     <= shadow_err_reg;
                shadow_err_reg <= capture & dec_illegal;
                stale_cnt_reg  <= '0;
            end else begin
                if (capture) begin
                    shadow_err_reg <= shadow_err_reg | dec_illegal;
                end
                if (stale_cnt_reg != STALE_LAST) begin
                    stale_cnt_reg <= stale_cnt_reg + TW'(1);
                end
            end
        end
    end

    assign stale = (stale_cnt_reg == STALE_LAST);

endmodule
